// File: rtl/imem_arbiter.sv
// Arbitrates a single-port synchronous instruction memory between fetch (F) and loader (L).
// Optional `ARB_PERF_CNT_EN adds conflict_cnt / force_cnt performance counters.
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            f_req,
  input  logic [ADDR_W-1:0]               f_addr,
  input  logic                            f_flush,
  output logic                            f_gnt,
  output logic                            f_rvalid,
  output logic [DATA_W-1:0]               f_rdata,
  input  logic                            l_req,
  input  logic                            l_we,
  input  logic [ADDR_W-1:0]               l_addr,
  input  logic [DATA_W-1:0]               l_wdata,
  output logic                            l_gnt,
  output logic                            l_rvalid,
  output logic [DATA_W-1:0]               l_rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]                     conflict_cnt,
  output logic [31:0]                     force_cnt,
`endif
  output logic                            dbg_state,
  output logic [$clog2(MAX_WAIT+1)-1:0]   dbg_wait_cnt
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {PRI_F = 1'b0, FORCE_L = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_F = 2'd1, OWN_L = 2'd2} owner_t;

  // Handshake: a request is accepted when req and gnt are both high in the same
  // cycle; the response (rvalid) follows exactly one cycle later, never stalls.

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    wait_inc;
  owner_t              owner_q, owner_d;
  logic                resp_we_q, resp_we_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
  logic                force_l;

  assign force_l  = (state_q == FORCE_L);
  assign wait_inc = wait_cnt_q + CNT_W'(1);

  // Grants are gated by reset so every output reads 0 while rst is low.
  always_comb begin
    l_gnt = rst & l_req & (force_l | ~f_req);
    f_gnt = rst & f_req & ~(force_l & l_req);
  end

  always_comb begin
    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_we ? l_wdata : '0;
    end
  end

  // FORCE_L lasts one cycle; a loader that gives up while refused loses its credit.
  always_comb begin
    state_d    = PRI_F;
    wait_cnt_d = '0;
    if (l_req && !l_gnt) begin
      if (wait_inc == CNT_W'(MAX_WAIT)) begin
        state_d = FORCE_L;
      end else begin
        wait_cnt_d = wait_inc;
      end
    end
  end

  always_comb begin
    owner_d   = OWN_NONE;
    resp_we_d = 1'b0;
    if (f_gnt) begin
      owner_d = OWN_F;
    end else if (l_gnt) begin
      owner_d   = OWN_L;
      resp_we_d = l_we;
    end
  end

  always_comb begin
    f_rvalid  = (owner_q == OWN_F) & ~f_flush;
    f_rdata_d = f_rvalid ? mem_rdata : f_rdata_q;
    l_rvalid  = (owner_q == OWN_L);
    l_rdata_d = (l_rvalid && !resp_we_q) ? mem_rdata : l_rdata_q;
    f_rdata   = f_rdata_d;
    l_rdata   = l_rdata_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PRI_F;
      wait_cnt_q <= '0;
      owner_q    <= OWN_NONE;
      resp_we_q  <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
      resp_we_q  <= resp_we_d;
      f_rdata_q  <= f_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] force_cnt_q, force_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q + ((f_req & l_req) ? 32'd1 : 32'd0);
    force_cnt_d    = force_cnt_q + ((force_l & l_gnt) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_q <= '0;
      force_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      force_cnt_q    <= force_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign force_cnt    = force_cnt_q;
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Arbitrates one single-port synchronous instruction memory between two requesters:
  - the fetch path (read-only, requester F);
  - a program loader / debug port (read/write, requester L).
- Sits between the fetch stage's program counter and the instruction memory array. The memory instance becomes arbiter-owned instead of fetch-owned.
- Fetch has priority by default. A bounded-wait counter guarantees loader forward progress.
- Fetch flush (branch redirect) discards stale fetch responses.

Parameters:
- ADDR_W, 32: address width of both requesters and the memory port.
- DATA_W, 32: data width.
- MAX_WAIT, 4: consecutive cycles L may be refused before it is force-granted. Must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch address.
- f_flush  in  1  branch redirect; kills fetch responses returned this cycle.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_W  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable.
- l_addr  in  ADDR_W  loader address.
- l_wdata  in  DATA_W  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid, or write acknowledge.
- l_rdata  out  DATA_W  loader read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=PRI_F, wait_cnt=0, resp_owner=NONE.
  - All outputs 0, including f_rdata and l_rdata.
  - Any in-flight response is discarded; no rvalid after reset release.
- Grant is combinational in the request cycle, at most one grant per cycle:
  - mem_en = f_gnt | l_gnt.
  - mem_addr/mem_we/mem_wdata are muxed from the granted requester.
  - mem_we is 0 when F is granted. All mem_* are 0 when idle.
- State PRI_F:
  - f_req=1 → f_gnt=1.
  - else l_req=1 → l_gnt=1.
- State FORCE_L:
  - l_req=1 → l_gnt=1, f_gnt=0 even if f_req=1.
  - l_req=0 → no loader grant; F is granted normally if f_req=1.
  - Always returns to PRI_F next cycle.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - +1 each cycle with l_req=1 and l_gnt=0.
  - Cleared on l_gnt=1 or l_req=0.
  - When the incremented value equals MAX_WAIT: next state is FORCE_L and the counter clears.
- Response tracking:
  - resp_owner registers the granted requester (F/L/NONE) each cycle.
  - Next cycle, that requester's rvalid=1 and rdata=mem_rdata.
  - Other rdata holds its last value.
  - Latency is exactly 1 cycle; back-to-back grants are allowed every cycle.
- Loader writes: l_rvalid=1 the next cycle as the acknowledge; l_rdata is not updated.
- Flush:
  - f_flush=1 forces f_rvalid=0 that cycle, and f_rdata is not updated.
  - A fetch granted in the same cycle as f_flush is the redirected fetch. It is not killed.
  - f_flush has no effect on L or on grants.
- Requesters hold req/addr/we/wdata stable until granted. The arbiter does not latch ungranted requests.
- Reset asserted mid-transaction: effects apply immediately (asynchronous). The memory write in a cycle where rst falls is not guaranteed.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - Adds outputs conflict_cnt[31:0] and force_cnt[31:0], both reset to 0.
  - conflict_cnt increments when f_req & l_req.
  - force_cnt increments on each l_gnt issued in FORCE_L.
  - Both counters wrap at 2^32.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then f_req=1 with f_addr=0x10 each cycle and mem returning 0x00000013 → f_gnt=1 every cycle; f_rvalid=1 from cycle 2 with f_rdata=0x13; l_* outputs stay 0.
- f_req=1 continuously, l_req=1 with l_addr=0x20, MAX_WAIT=4 → l_gnt=0 for 4 cycles, then l_gnt=1 and f_gnt=0 in cycle 5; f_gnt=1 again in cycle 6.
- f_req=0, l_req=1, l_we=1, l_addr=0x8, l_wdata=0xDEADBEEF → same cycle mem_en=1, mem_we=1, mem_addr=0x8, mem_wdata=0xDEADBEEF; next cycle l_rvalid=1.
- f_gnt at cycle N (addr 0x4), f_flush=1 at N+1 with f_req=1 and f_addr=0x40 → f_rvalid=0 at N+1; f_rvalid=1 at N+2 with the data for 0x40.
- Loader forced at cycle N but l_req drops at N → no grant to L, F is granted if requesting, state returns to PRI_F, wait_cnt=0.
- rst=0 asynchronously one cycle after f_gnt → f_rvalid stays 0 through reset and after its release; with ARB_PERF_CNT_EN, conflict_cnt=0 and force_cnt=0.
